// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions.
// Holds the RAM status encoding, the memory arbiter grant states, the
// default address/data widths, and a small saturating-increment helper.
package cpu_types_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  // Increment v, but never beyond lim.
  function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
    return (v < lim) ? v + 4'd1 : lim;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one single-ported, variable-latency RAM between the
// instruction-fetch port and the data port of the CPU.
//   CLK, RST             clock (rising edge), asynchronous active-high reset
//   iREN/iaddr           instruction read request and address
//   iload/iwait          instruction read data / access-not-complete flag
//   dREN/dWEN/daddr/dstore  data read/write request, address, write value
//   dload/dwait          data read value / access-not-complete flag
//   ramREN/ramWEN/ramaddr/ramstore  RAM request side
//   ramload/ramstate     RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err                  sticky flag, set by any RAM ERROR response
// Data has priority; after STARVE_MAX consecutive data completions with a
// fetch waiting, the fetch is granted next.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err
);

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  arb_state_t state, next_state;
  logic [3:0] starve_cnt, next_cnt;
  logic       set_err;
  logic       dreq;
  logic       done;
  ramstate_t  rs;

  assign dreq = dREN | dWEN;
  assign rs   = ramstate_t'(ramstate);
  assign done = (rs == ACCESS) || (rs == ERROR);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      err        <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_cnt;
      if (set_err) err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = starve_cnt;
    set_err    = 1'b0;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;

    case (state)
      IDLE: begin
        // A saturated counter hands the next slot to a waiting fetch.
        if (dreq && ((starve_cnt < CNT_MAX) || !iREN)) next_state = DGRANT;
        else if (iREN)                                 next_state = IGRANT;
      end

      DGRANT: begin
        if (!dreq) begin
          // Requester withdrew: release the RAM without completing.
          next_state = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (done) begin
            dwait      = 1'b0;
            dload      = (rs == ACCESS && !dWEN) ? ramload : '0;
            set_err    = (rs == ERROR);
            next_state = IDLE;
            next_cnt   = iREN ? sat_inc(starve_cnt, CNT_MAX) : 4'd0;
          end
        end
      end

      IGRANT: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (done) begin
            iwait      = 1'b0;
            iload      = (rs == ACCESS) ? ramload : '0;
            set_err    = (rs == ERROR);
            next_state = IDLE;
            next_cnt   = 4'd0;
          end
        end
      end

      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int SM = 4;
  localparam int OWN_NONE = 0, OWN_D = 1, OWN_I = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = 2'd0;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model: who owns the RAM, how many data completions in a row
  // happened while a fetch waited, and whether an error was ever reported.
  int   m_own = OWN_NONE;
  int   m_cnt = 0;
  logic m_err = 1'b0;

  // Observed values of the last stepped cycle, for directed checks.
  logic        o_iwait, o_dwait, o_ramREN, o_ramWEN;
  logic [31:0] o_iload, o_dload, o_ramaddr, o_ramstore;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = OWN_NONE;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  // One clock cycle: apply inputs, compare the combinational outputs with
  // the model, then advance the model across the rising edge.
  task automatic step(input logic ire, input logic dre, input logic dwe,
                      input logic [31:0] ia, input logic [31:0] da,
                      input logic [31:0] ds, input logic [31:0] rl,
                      input logic [1:0] rs);
    logic        e_iw, e_dw, e_ren, e_wen;
    logic [31:0] e_il, e_dl, e_ra, e_rs;
    logic        answered;
    iREN = ire; dREN = dre; dWEN = dwe;
    iaddr = ia; daddr = da; dstore = ds; ramload = rl; ramstate = rs;
    #3;
    answered = (rs == 2'd2) || (rs == 2'd3);
    e_iw = 1'b1; e_dw = 1'b1; e_il = '0; e_dl = '0;
    e_ren = 1'b0; e_wen = 1'b0; e_ra = '0; e_rs = '0;
    if (m_own == OWN_D && (dre || dwe)) begin
      e_ra = da; e_rs = ds;
      e_wen = dwe;
      e_ren = dre && !dwe;
      if (answered) begin
        e_dw = 1'b0;
        e_dl = (rs == 2'd2 && !dwe) ? rl : 32'h0;
      end
    end else if (m_own == OWN_I && ire) begin
      e_ra = ia; e_ren = 1'b1;
      if (answered) begin
        e_iw = 1'b0;
        e_il = (rs == 2'd2) ? rl : 32'h0;
      end
    end
    chk("iwait",    32'(iwait),    32'(e_iw));
    chk("dwait",    32'(dwait),    32'(e_dw));
    chk("iload",    iload,         e_il);
    chk("dload",    dload,         e_dl);
    chk("ramREN",   32'(ramREN),   32'(e_ren));
    chk("ramWEN",   32'(ramWEN),   32'(e_wen));
    chk("ramaddr",  ramaddr,       e_ra);
    chk("ramstore", ramstore,      e_rs);
    chk("err",      32'(err),      32'(m_err));
    o_iwait = iwait; o_dwait = dwait; o_ramREN = ramREN; o_ramWEN = ramWEN;
    o_iload = iload; o_dload = dload; o_ramaddr = ramaddr; o_ramstore = ramstore;
    @(posedge CLK);
    if (m_own == OWN_D) begin
      if (!(dre || dwe)) m_own = OWN_NONE;
      else if (answered) begin
        if (rs == 2'd3) m_err = 1'b1;
        m_cnt = ire ? ((m_cnt < SM) ? m_cnt + 1 : SM) : 0;
        m_own = OWN_NONE;
      end
    end else if (m_own == OWN_I) begin
      if (!ire) m_own = OWN_NONE;
      else if (answered) begin
        if (rs == 2'd3) m_err = 1'b1;
        m_cnt = 0;
        m_own = OWN_NONE;
      end
    end else begin
      if ((dre || dwe) && (m_cnt < SM || !ire)) m_own = OWN_D;
      else if (ire)                              m_own = OWN_I;
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_iwait"},  32'(iwait),  32'd1);
    chk({pfx, "_dwait"},  32'(dwait),  32'd1);
    chk({pfx, "_ramREN"}, 32'(ramREN), 32'd0);
    chk({pfx, "_ramWEN"}, 32'(ramWEN), 32'd0);
    chk({pfx, "_ramaddr"}, ramaddr,    32'd0);
    chk({pfx, "_iload"},  iload,       32'd0);
    chk({pfx, "_dload"},  dload,       32'd0);
    chk({pfx, "_err"},    32'(err),    32'd0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("rst");
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Random traffic with held-until-done requesters and occasional aborts.
  task automatic random_phase(input int cycles, input bit allow_err);
    logic        d_pend = 1'b0, d_rd = 1'b0, d_wr = 1'b0, i_pend = 1'b0;
    logic [31:0] d_a = '0, d_s = '0, i_a = '0;
    logic [1:0]  rs;
    int          r;
    for (int c = 0; c < cycles; c++) begin
      if (!d_pend && ($urandom % 3 == 0)) begin
        d_pend = 1'b1;
        r = $urandom % 3;
        d_rd = (r != 1);
        d_wr = (r != 0);
        d_a = $urandom; d_s = $urandom;
      end
      if (!i_pend && ($urandom % 2 == 0)) begin
        i_pend = 1'b1;
        i_a = $urandom;
      end
      if (d_pend && ($urandom % 40 == 0)) d_pend = 1'b0;
      if (i_pend && ($urandom % 40 == 0)) i_pend = 1'b0;
      r = $urandom % 100;
      if (r < 20)                     rs = 2'd0;
      else if (r < 50)                rs = 2'd1;
      else if (r < 95 || !allow_err)  rs = 2'd2;
      else                            rs = 2'd3;
      step(i_pend, d_pend && d_rd, d_pend && d_wr, i_a, d_a, d_s, $urandom, rs);
      if (!o_dwait) d_pend = 1'b0;
      if (!o_iwait) i_pend = 1'b0;
    end
  endtask

  initial begin
    int first_low, lows, wen_seen;
    int comp[$];
    logic [31:0] ia_s;

    // Power-up reset
    #1;
    check_reset_outputs("por");
    @(posedge CLK);
    do_reset();

    random_phase(300, 1'b0);

    // Fetch only, RAM answers on the third granted cycle
    do_reset();
    first_low = -1; lows = 0; wen_seen = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 32'h8C220004,
           (k == 3) ? 2'd2 : ((k == 2) ? 2'd1 : 2'd0));
      if (!o_iwait) begin
        lows++;
        if (first_low < 0) first_low = k;
        chk("fetch_iload", o_iload, 32'h8C220004);
      end
      if (o_ramWEN) wen_seen++;
    end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    chk("fetch_latency", 32'(first_low), 32'd3);
    chk("fetch_lows", 32'(lows), 32'd1);
    chk("fetch_wen", 32'(wen_seen), 32'd0);

    // Simultaneous requests: data first, then turnaround, then fetch
    ia_s = 32'h0000_0080;
    step(1'b1, 1'b1, 1'b0, ia_s, 32'h100, 32'h0, 32'hDEADBEEF, 2'd2);
    chk("simul_idle_ren", 32'(o_ramREN), 32'd0);
    step(1'b1, 1'b1, 1'b0, ia_s, 32'h100, 32'h0, 32'hDEADBEEF, 2'd2);
    chk("simul_dwait", 32'(o_dwait), 32'd0);
    chk("simul_dload", o_dload, 32'hDEADBEEF);
    chk("simul_daddr", o_ramaddr, 32'h100);
    chk("simul_iwait", 32'(o_iwait), 32'd1);
    step(1'b1, 1'b0, 1'b0, ia_s, 32'h0, 32'h0, 32'h0, 2'd2);
    chk("simul_turn_ren", 32'(o_ramREN), 32'd0);
    chk("simul_turn_iwait", 32'(o_iwait), 32'd1);
    step(1'b1, 1'b0, 1'b0, ia_s, 32'h0, 32'h0, 32'h1111, 2'd1);
    chk("simul_igrant_ren", 32'(o_ramREN), 32'd1);
    chk("simul_igrant_addr", o_ramaddr, ia_s);
    step(1'b1, 1'b0, 1'b0, ia_s, 32'h0, 32'h0, 32'h2222, 2'd2);
    chk("simul_iload", o_iload, 32'h2222);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);

    // Write with read also asserted
    step(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'h12345678, 32'hFFFFFFFF, 2'd2);
    step(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 32'h12345678, 32'hFFFFFFFF, 2'd2);
    chk("wr_wen", 32'(o_ramWEN), 32'd1);
    chk("wr_ren", 32'(o_ramREN), 32'd0);
    chk("wr_store", o_ramstore, 32'h12345678);
    chk("wr_dwait", 32'(o_dwait), 32'd0);
    chk("wr_dload", o_dload, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);

    // Sustained data traffic with a waiting fetch
    do_reset();
    for (int k = 0; k < 30; k++) begin
      step(1'b1, 1'b1, 1'b0, 32'h44, 32'h88, 32'h0, $urandom, 2'd2);
      if (!o_dwait) comp.push_back(0);
      if (!o_iwait) comp.push_back(1);
    end
    chk("starve_total", 32'(comp.size()), 32'd15);
    foreach (comp[k]) chk($sformatf("starve_seq%0d", k), 32'(comp[k]), (k % 5 == 4) ? 32'd1 : 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);

    // ERROR during a fetch, then err stays set through a good access
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'hAAAA5555, 2'd3);
    chk("ierr_iwait", 32'(o_iwait), 32'd0);
    chk("ierr_iload", o_iload, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    chk("ierr_sticky", 32'(err), 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 32'h5, 2'd2);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 32'h5, 2'd2);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);
    chk("ierr_sticky2", 32'(err), 32'd1);

    // Reset in the middle of a busy data grant
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 32'h0, 2'd1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 32'h0, 2'd1);
    chk("mid_granted", 32'(o_ramREN), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("mid_ramREN", 32'(ramREN), 32'd0);
    chk("mid_dwait", 32'(dwait), 32'd1);
    chk("mid_err", 32'(err), 32'd0);
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 32'h0, 2'd1);
    chk("mid_after_idle", 32'(o_ramREN), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 32'h0, 2'd2);
    chk("mid_after_grant", 32'(o_ramREN), 32'd1);
    chk("mid_after_done", 32'(o_dwait), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0);

    random_phase(300, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the instruction-fetch port and the data port of the pipelined CPU onto one single-ported, variable-latency RAM.
- Its dwait output is the dhit-complement the hazard unit uses to stall the pipeline on memory accesses.
- Data accesses have priority over instruction fetches. A starvation counter guarantees fetch progress under sustained data traffic.
- Registered grant FSM; the RAM side is driven only by the granted requester.

Parameters:
ADDR_W, 32, address width (byte addresses)
DATA_W, 32, data word width
STARVE_MAX, 4, consecutive data completions with a fetch pending before the fetch is forced ahead; range 1..15

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
iREN  in  1  instruction read request; held until iwait low
iaddr  in  ADDR_W  instruction address
iload  out  DATA_W  instruction read data, valid when iwait low
iwait  out  1  high = instruction access not complete
dREN  in  1  data read request; held until dwait low
dWEN  in  1  data write request; held until dwait low
daddr  in  ADDR_W  data address
dstore  in  DATA_W  data write value
dload  out  DATA_W  data read value, valid when dwait low
dwait  out  1  high = data access not complete
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
err  out  1  sticky: a RAM ERROR response was seen

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - state=IDLE, starve_cnt=0, err=0.
  - Outputs: iwait=1, dwait=1, iload=0, dload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - An in-flight transaction is abandoned; the requester must re-present it after reset.
- States: IDLE, DGRANT, IGRANT. State and starve_cnt are registered; all outputs are combinational from state plus inputs.
- IDLE:
  - RAM outputs are 0; iwait=dwait=1.
  - At the next edge:
    - If dreq=(dREN|dWEN) and (starve_cnt<STARVE_MAX or !iREN): go to DGRANT.
    - Else if iREN: go to IGRANT.
    - Else stay in IDLE.
- DGRANT:
  - RAM side driven from the data port: ramaddr=daddr, ramstore=dstore.
  - Read/write enables: if dWEN, ramWEN=1 and ramREN=0 (write wins when both are asserted); else ramREN=dREN.
  - On ramstate==ACCESS: dwait=0 this cycle, dload=ramload (reads only; 0 for writes), next state=IDLE.
  - Counter update on that completion: if iREN is high, starve_cnt=min(starve_cnt+1, STARVE_MAX); else starve_cnt=0.
  - On ramstate==ERROR: completes like ACCESS but dload=0, and err is set at the edge.
  - FREE/BUSY: dwait=1; hold DGRANT.
  - dREN and dWEN both low while granted (flush/abort): drive RAM enables 0 this cycle, go to IDLE, no completion, starve_cnt unchanged.
- IGRANT:
  - Mirror of DGRANT using iaddr, ramREN=iREN, ramWEN=0, iwait, iload.
  - Completion (ACCESS or ERROR) clears starve_cnt to 0 and returns to IDLE.
  - iREN dropped while granted: go to IDLE, no completion.
- Timing:
  - Minimum latency is 2 cycles: request seen in IDLE, granted, then RAM answers ACCESS in the first granted cycle.
  - Back-to-back accesses always pass through one IDLE turnaround cycle.
  - The non-granted port always sees wait=1 and load=0.
- Simultaneous events:
  - iREN and dreq rise in the same cycle: data wins unless starve_cnt==STARVE_MAX.
  - The IGRANT forced by starvation clears the counter on completion.
- err is cleared only by RST.

Decomposition:
- Shared package cpu_types_pkg holds:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR), 2 bits
  - arb_state_t enum (IDLE, DGRANT, IGRANT)
  - ADDR_W and DATA_W defaults
- No sub-module. The starvation counter is a few lines inside the arbiter.

Test Plan:
- Reset mid-DGRANT with ramstate=BUSY -> same cycle: ramREN=0, dwait=1, err=0; next legal grant starts from IDLE.
- iREN=1 only, RAM returns ACCESS on the 3rd granted cycle with ramload=0x8C220004 -> iwait low exactly one cycle with iload=0x8C220004, ramWEN never high, 4 cycles total from request.
- iREN=1 and dREN=1 rise together, daddr=0x100, RAM returns 0xDEADBEEF -> DGRANT first, dload=0xDEADBEEF; then IDLE, then IGRANT.
- dWEN=1 with dREN=1, dstore=0x12345678, daddr=0x200 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dload=0 on completion.
- dreq held continuously with iREN held, STARVE_MAX=4 -> exactly 4 data completions, then 1 instruction completion, pattern repeats; starve_cnt never exceeds 4.
- ramstate=ERROR during IGRANT -> iwait low one cycle, iload=0, err=1 and remains 1 through later successful accesses until RST.
